demux_ctrl: RTL and testbench

DEMUX_CTRL -- requirements
Module: demux_ctrl

---
 rtl/demux_ctrl_pkg.sv | 13 +
 rtl/demux_ctrl_rr_pick.sv | 24 ++
 rtl/demux_ctrl.sv | 96 +++++++++
 tb/tb_demux_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/demux_ctrl_pkg.sv
// Shared constants and types for the demux_ctrl one-entry routing buffer.
package demux_ctrl_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam logic [7:0] DROP_SAT = 8'hFF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_ctrl_rr_pick.sv
// Round-robin search: first enabled output strictly after rr_ptr, wrapping.
module rr_pick
  import demux_ctrl_pkg::*;
(
  input  logic [N_OUT-1:0] en,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any_en
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest enabled index wins.
  always_comb begin
    grant  = rr_ptr;
    any_en = |en;
    idx    = '0;
    for (int k = N_OUT; k >= 1; k--) begin
      idx = rr_ptr + SEL_W'(k);
      if (en[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/demux_ctrl.sv
// One-entry demux buffer: routes each accepted beat to a directed or
// round-robin output, dropping beats whose target output is disabled.
module demux_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [N_OUT-1:0]  en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  s,
  output logic [7:0]        drop_cnt
);

  // Handshake: upstream beat transfers when in_valid & in_ready; the held
  // beat transfers when out_valid[s] & out_ready[s]. Other out_ready bits
  // are ignored.

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  s_q, s_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        drop_q, drop_d;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  target;
  logic              any_en;
  logic              accept;
  logic              rel_beat;
  logic              keep;

  rr_pick u_rr_pick (
    .en     (en),
    .rr_ptr (rr_q),
    .grant  (grant),
    .any_en (any_en)
  );

  assign in_ready = (state_q == EMPTY) | out_ready[s_q];

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    rr_d     = rr_q;
    data_d   = data_q;
    drop_d   = drop_q;
    accept   = in_valid & in_ready;
    rel_beat = (state_q == FULL) & out_ready[s_q];
    target   = mode ? grant : in_dest;
    keep     = accept & (mode ? any_en : en[in_dest]);

    if (keep) begin
      state_d = FULL;
      s_d     = target;
      rr_d    = target;
      data_d  = in_data;
    end else begin
      if (rel_beat) state_d = EMPTY;
      if (accept && (drop_q != DROP_SAT)) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      s_q     <= '0;
      rr_q    <= '1;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N_OUT; i++)
      out_valid[i] = (state_q == FULL) && (s_q == SEL_W'(i));
  end

  assign out_data = data_q;
  assign s        = s_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_ctrl.sv
// Directed and random stimulus for demux_ctrl, checked every cycle against
// a transaction-level model of the routing buffer.
module tb_demux_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [3:0] en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] s;
  logic [7:0] drop_cnt;

  int checks = 0;
  int fails  = 0;

  // Reference model: a held beat (or nothing), last grant, drop counter.
  bit         m_full;
  logic [7:0] m_data;
  int         m_s;
  int         m_rr;
  int         m_drop;

  always #5 clk = ~clk;

  demux_ctrl #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .s         (s),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_target(input int rr, input logic [3:0] e);
    for (int k = 1; k <= 4; k++)
      if (e[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 8'h00; m_s = 0; m_rr = 3; m_drop = 0;
  endtask

  // Applies one cycle of inputs: checks outputs before the edge, then
  // advances the model with the same inputs the DUT sees at the edge.
  task automatic cyc(input bit r, input bit md, input logic [3:0] e, input bit iv,
                     input logic [7:0] d, input logic [1:0] dst, input logic [3:0] ordy);
    bit exp_ready, acc, rel;
    int tgt;
    rst_n = r; mode = md; en = e; in_valid = iv; in_data = d; in_dest = dst; out_ready = ordy;
    #1;
    exp_ready = !m_full || ordy[m_s];
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), m_full ? (32'd1 << m_s) : 32'd0);
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("s", 32'(s), 32'(m_s));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (!r) begin
      model_reset();
    end else begin
      acc = iv && exp_ready;
      rel = m_full && ordy[m_s];
      tgt = md ? rr_target(m_rr, e) : int'(dst);
      if (acc && tgt >= 0 && e[tgt]) begin
        m_full = 1; m_data = d; m_s = tgt; m_rr = tgt;
      end else begin
        if (rel) m_full = 0;
        if (acc && m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; en = 4'h0; in_valid = 1'b0;
    in_data = 8'h00; in_dest = 2'd0; out_ready = 4'h0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset, then round-robin sweep at full throughput.
    cyc(0, 0, 4'h0, 0, 8'h00, 2'd0, 4'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 4'hF, 1, 8'(i), 2'd0, 4'hF);
      chk("rr_seq_s", 32'(s), 32'((i - 1) % 4));
      chk("rr_seq_data", 32'(out_data), 32'(i));
    end
    cyc(1, 1, 4'hF, 0, 8'h00, 2'd0, 4'hF);

    // Directed beat to a disabled output drops; enabled output delivers.
    cyc(1, 0, 4'b1011, 1, 8'hA5, 2'd2, 4'h0);
    chk("drop_no_valid", 32'(out_valid), 32'h0);
    chk("drop_cnt_one", 32'(drop_cnt), 32'd1);
    cyc(1, 0, 4'b1011, 1, 8'h5A, 2'd3, 4'h0);
    chk("dir_valid", 32'(out_valid), 32'b1000);
    chk("dir_data", 32'(out_data), 32'h5A);
    cyc(1, 0, 4'b1011, 0, 8'h00, 2'd0, 4'hF);

    // Backpressure: held beat stays stable, then release and reload together.
    cyc(1, 0, 4'hF, 1, 8'h11, 2'd1, 4'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 4'hF, 1, 8'h22, 2'd1, 4'b1101);
      chk("bp_hold_valid", 32'(out_valid), 32'b0010);
      chk("bp_hold_data", 32'(out_data), 32'h11);
    end
    cyc(1, 0, 4'hF, 1, 8'h22, 2'd1, 4'b0010);
    chk("reload_valid", 32'(out_valid), 32'b0010);
    chk("reload_data", 32'(out_data), 32'h22);
    cyc(1, 0, 4'hF, 0, 8'h00, 2'd0, 4'hF);

    // Sparse enable mask round-robin, then drop counter saturation.
    cyc(0, 1, 4'b0101, 0, 8'h00, 2'd0, 4'h0);
    cyc(1, 1, 4'b0101, 1, 8'h01, 2'd0, 4'hF);
    chk("sparse_first", 32'(s), 32'd0);
    cyc(1, 1, 4'b0101, 1, 8'h02, 2'd0, 4'hF);
    chk("sparse_g1", 32'(s), 32'd2);
    cyc(1, 1, 4'b0101, 1, 8'h03, 2'd0, 4'hF);
    chk("sparse_g2", 32'(s), 32'd0);
    cyc(1, 1, 4'b0101, 1, 8'h04, 2'd0, 4'hF);
    chk("sparse_g3", 32'(s), 32'd2);
    for (int i = 0; i < 300; i++)
      cyc(1, 1, 4'h0, 1, 8'(i), 2'd0, 4'hF);
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset discards a held beat.
    cyc(1, 0, 4'hF, 1, 8'h3C, 2'd2, 4'h0);
    cyc(1, 0, 4'hF, 0, 8'h00, 2'd0, 4'h0);
    chk("held_3c", 32'(out_data), 32'h3C);
    cyc(0, 0, 4'hF, 0, 8'h00, 2'd0, 4'hF);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_s", 32'(s), 32'h0);
    cyc(1, 0, 4'hF, 0, 8'h00, 2'd0, 4'hF);
    chk("never_delivered", 32'(out_valid), 32'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
